// File: rtl/target_pkg.sv
// target_pkg: shared types, colours, LFSR seed and geometry helpers for target_engine
package target_pkg;

    typedef enum logic [1:0] {MOVING, HIT, RESPAWN} state_e;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t FLASH_EVEN = 12'hFFF;
    localparam rgb444_t FLASH_ODD  = 12'hFF0;
    localparam rgb444_t XHAIR      = 12'h0F0;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Half-open box test: [bx, bx+size) x [by, by+size), widened to avoid wrap at the screen edge
    function automatic logic in_box(input logic [9:0] px, py, bx, by, input logic [10:0] size);
        return ({1'b0, px} >= {1'b0, bx}) && ({1'b0, px} < {1'b0, bx} + size) &&
               ({1'b0, py} >= {1'b0, by}) && ({1'b0, py} < {1'b0, by} + size);
    endfunction

    function automatic logic near8(input logic [9:0] a, b);
        return ((a >= b) ? a - b : b - a) <= 10'd8;
    endfunction

endpackage

// File: rtl/target_engine_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for respawn placement
module lfsr16
    import target_pkg::*;
(
    input  logic        clk25,
    input  logic        reset_n,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;

    // Shift right, feeding the tap parity into the top bit every cycle
    always_ff @(posedge clk25) begin
        if (!reset_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/target_engine.sv
// target_engine: bouncing target, shot scoring and 1-cycle RGB render (crosshair overlay with CROSSHAIR_EN)
module target_engine
    import target_pkg::*;
#(
    parameter int      HRES       = 640,
    parameter int      VRES       = 480,
    parameter int      TSIZE      = 32,
    parameter int      STEP       = 2,
    parameter int      HIT_FRAMES = 30,
    parameter rgb444_t BG_COLOR   = 12'h003,
    parameter rgb444_t TGT_COLOR  = 12'hF00
) (
    input  logic        clk25,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        inDisplayArea,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        frame,
    input  logic        shot,
    input  logic [9:0]  aim_x,
    input  logic [9:0]  aim_y,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [7:0]  score
);

    localparam logic signed [10:0] XMAX     = 11'(HRES - TSIZE);
    localparam logic signed [10:0] YMAX     = 11'(VRES - TSIZE);
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic [4:0]         HIT_LAST = 5'(HIT_FRAMES - 1);

    state_e             state_q, state_d;
    logic [9:0]         tx_q, tx_d, ty_q, ty_d;
    logic signed [10:0] vx_q, vx_d, vy_q, vy_d;
    logic               pend_q, pend_d;
    logic [4:0]         hit_cnt_q, hit_cnt_d;
    logic [7:0]         score_q, score_d;
    rgb444_t            rgb_q, rgb_d;
    logic               hs_q, vs_q;
    logic [15:0]        lfsr;
    logic signed [10:0] nx, ny;
    logic               tgt_px, xh;

    lfsr16 u_lfsr (.clk25(clk25), .reset_n(reset_n), .lfsr(lfsr));

`ifdef CROSSHAIR_EN
    assign xh = (x == aim_x && near8(y, aim_y)) || (y == aim_y && near8(x, aim_x));
`else
    assign xh = 1'b0;
`endif

    assign tgt_px = in_box(x, y, tx_q, ty_q, 11'(TSIZE));
    assign rgb_d  = !inDisplayArea       ? '0 :
                    xh                   ? XHAIR :
                    !tgt_px              ? BG_COLOR :
                    (state_q == MOVING)  ? TGT_COLOR :
                    (state_q == HIT)     ? (hit_cnt_q[0] ? FLASH_ODD : FLASH_EVEN) :
                                           BG_COLOR;

    // Game state advances only on the frame pulse; shots are latched in between
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        hit_cnt_d = hit_cnt_q;
        score_d   = score_q;
        pend_d    = pend_q || (shot && state_q == MOVING);
        nx        = $signed({1'b0, tx_q}) + vx_q;
        ny        = $signed({1'b0, ty_q}) + vy_q;
        if (frame) begin
            pend_d = shot && state_q == MOVING;
            case (state_q)
                MOVING: begin
                    if (pend_q && in_box(aim_x, aim_y, tx_q, ty_q, 11'(TSIZE))) begin
                        score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        hit_cnt_d = '0;
                        state_d   = HIT;
                    end else begin
                        if (nx <= 11'sd0) begin
                            tx_d = '0;
                            vx_d = STEP_S;
                        end else if (nx >= XMAX) begin
                            tx_d = XMAX[9:0];
                            vx_d = -STEP_S;
                        end else begin
                            tx_d = nx[9:0];
                        end
                        if (ny <= 11'sd0) begin
                            ty_d = '0;
                            vy_d = STEP_S;
                        end else if (ny >= YMAX) begin
                            ty_d = YMAX[9:0];
                            vy_d = -STEP_S;
                        end else begin
                            ty_d = ny[9:0];
                        end
                    end
                end
                HIT: begin
                    hit_cnt_d = hit_cnt_q + 5'd1;
                    state_d   = (hit_cnt_q == HIT_LAST) ? RESPAWN : HIT;
                end
                RESPAWN: begin
                    tx_d    = {1'b0, lfsr[8:0]};
                    ty_d    = {2'b00, lfsr[15:8]} + 10'd100;
                    state_d = MOVING;
                end
                default: state_d = MOVING;
            endcase
        end
    end

    // State, position and render registers with synchronous active-low reset
    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            state_q   <= MOVING;
            tx_q      <= 10'(HRES / 2 - TSIZE / 2);
            ty_q      <= 10'(VRES / 2 - TSIZE / 2);
            vx_q      <= STEP_S;
            vy_q      <= STEP_S;
            pend_q    <= 1'b0;
            hit_cnt_q <= '0;
            score_q   <= '0;
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            pend_q    <= pend_d;
            hit_cnt_q <= hit_cnt_d;
            score_q   <= score_d;
            rgb_q     <= rgb_d;
            hs_q      <= hsync;
            vs_q      <= vsync;
        end
    end

    assign rgb       = rgb_q;
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;
    assign score     = score_q;

endmodule

// File: doc/target_engine.md
Name: target_engine

Overview:
- Pixel-rate stage directly downstream of the VGA timing generator in the target-shooting demo.
- Consumes pixel coordinates, display-area flag, sync signals and the end-of-active-frame pulse.
- Moves a bouncing square target once per frame and evaluates player shots against it.
- Outputs registered 12-bit RGB with sync signals delayed to stay aligned with the pixel data.

Parameters:
HRES, 640, active pixels per line
VRES, 480, active lines
TSIZE, 32, target edge length in pixels
STEP, 2, target displacement per frame on each axis, in pixels
HIT_FRAMES, 30, number of frames the hit-flash state lasts
BG_COLOR, 12'h003, background RGB444
TGT_COLOR, 12'hF00, target RGB444

Ports:
clk25  in  1  25 MHz pixel clock
reset_n  in  1  synchronous active-low reset
x  in  10  current pixel column
y  in  10  current pixel line
inDisplayArea  in  1  1 = pixel is in the active area
hsync  in  1  horizontal sync, active low
vsync  in  1  vertical sync, active low
frame  in  1  one-cycle pulse at the start of line VRES
shot  in  1  one-cycle fire request
aim_x  in  10  crosshair column
aim_y  in  10  crosshair line
rgb  out  12  registered pixel colour
hsync_out  out  1  hsync delayed 1 cycle
vsync_out  out  1  vsync delayed 1 cycle
score  out  8  hit counter

Behaviour:
- Clock and reset (already decided): single clock clk25; reset_n is synchronous and active-low, sampled on the rising edge of clk25.
- Reset values:
  - rgb = 0, hsync_out = 1, vsync_out = 1, score = 0
  - state = MOVING, tx = HRES/2 - TSIZE/2 (304), ty = VRES/2 - TSIZE/2 (224)
  - vx = +STEP, vy = +STEP, shot_pending = 0, hit_cnt = 0, LFSR = 16'hACE1
- Render pipeline latency is exactly 1 cycle:
  - rgb, hsync_out and vsync_out are registered from the same-cycle inputs.
  - rgb = 0 whenever inDisplayArea = 0.
- Inside target: x in [tx, tx+TSIZE) and y in [ty, ty+TSIZE), inclusive of tx and ty.
  - In MOVING: target pixels use TGT_COLOR.
  - In HIT: target pixels use 12'hFFF on even hit_cnt and 12'hFF0 on odd hit_cnt.
  - All other active pixels use BG_COLOR.
- State and position update only on cycles where frame = 1, so the target never tears mid-frame.
- MOVING:
  - Position arithmetic is signed 11-bit: nx = tx + vx.
  - If nx <= 0: tx = 0 and vx = +STEP.
  - Else if nx >= HRES - TSIZE: tx = HRES - TSIZE and vx = -STEP.
  - Else tx = nx. The y axis behaves the same way against VRES.
  - If shot_pending and the aim point is inside the pre-update target: score saturating-increments (holds at 255), hit_cnt = 0, go to HIT, position frozen.
  - On a miss, nothing changes except clearing shot_pending.
  - shot_pending is cleared at every frame pulse.
- HIT:
  - hit_cnt increments on each frame pulse.
  - When hit_cnt = HIT_FRAMES-1 at a frame pulse: go to RESPAWN.
- RESPAWN:
  - At the next frame pulse: tx = lfsr[8:0], ty = lfsr[15:8] + 100, velocity keeps its sign, go to MOVING.
  - This placement is valid for the default parameters.
- Shots:
  - shot sets shot_pending only in MOVING; it is ignored in HIT and RESPAWN.
  - If shot and frame are both 1 in the same cycle, the frame evaluation uses the old shot_pending and the new shot stays pending for the next frame.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle.
- Reset asserted mid-frame restores all reset values on that edge; the next rgb is 0.

Optional Feature:
- Macro CROSSHAIR_EN.
- Defined: active pixels with (x == aim_x and |y - aim_y| <= 8) or (y == aim_y and |x - aim_x| <= 8) render 12'h0F0, with priority over the target and background. Latency is unchanged.
- Undefined: no crosshair logic is generated and the aim inputs are used only for hit testing.

Decomposition:
- Package target_pkg holds:
  - state enum typedef {MOVING, HIT, RESPAWN}
  - RGB444 typedef
  - colour constants 12'hFFF, 12'hFF0, 12'h0F0
  - LFSR seed
- Sub-module lfsr16: clk25 and reset_n in, 16-bit state out, free-running.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> rgb=0, hsync_out=vsync_out=1, score=0; the first rendered frame shows the target at (304,224)-(335,255).
- Latency: drive x=304, y=224, inDisplayArea=1 -> rgb=12'hF00 one cycle later; the same pixel with inDisplayArea=0 -> rgb=0. hsync toggles are mirrored on hsync_out one cycle later.
- Bounce: run frames until tx reaches 608 -> vx becomes -2 and on the next frame tx=606; at tx=0, vx becomes +2.
- Hit: shot=1 with aim=(tx+5, ty+5), then a frame pulse -> score=1; target flashes FFF/FF0 for 30 frames, then respawns at (lfsr[8:0], lfsr[15:8]+100).
- Miss and ignore: aim=(0,0) while the target is away from the origin -> score unchanged and pending cleared; a shot during HIT -> score unchanged after respawn.
- Saturation and collision: preload score to 255 and hit -> stays 255; shot and frame in the same cycle -> evaluated at the following frame pulse.
